handwriting_canvas: RTL

Capture block directly upstream of the VGA top level. It turns PS/2 mouse left-button strokes into a 28x28 binary bitmap held in registers. It supplies a per-pixel overlay bit for the VGA pixel mux, in step with h_cnt/v_cnt. On request it streams the bitmap row-major over a valid/ready interface to the digit recogniser.

---
 rtl/handwriting_canvas.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/handwriting_canvas.sv
// Mouse-stroke capture into a GRID x GRID bitmap, with VGA overlay readout and row-major bit streaming.
// Optional macro BRUSH3_EN: a draw event inks the clipped 3x3 neighbourhood instead of a single cell.
module handwriting_canvas #(
    parameter int unsigned GRID       = 28,
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned ORIGIN_X   = 208,
    parameter int unsigned ORIGIN_Y   = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       mouse_left,
    input  logic       mouse_event,
    input  logic       clear,
    input  logic       submit,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       pix_in_canvas,
    output logic       pix_on,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       busy
);

    localparam int unsigned   CW   = $clog2(GRID);
    localparam logic [9:0]    SPAN = 10'(GRID << CELL_SHIFT);
    localparam logic [9:0]    OX   = 10'(ORIGIN_X);
    localparam logic [9:0]    OY   = 10'(ORIGIN_Y);
    localparam logic [CW-1:0] LAST = CW'(GRID - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_STREAM} state_t;

    function automatic logic in_span(input logic [9:0] p, input logic [9:0] org);
        return (p >= org) && (p < org + SPAN);
    endfunction

    // Only meaningful once in_span holds, so the wrapped subtraction never matters.
    function automatic logic [CW-1:0] to_cell(input logic [9:0] p, input logic [9:0] org);
        return CW'((p - org) >> CELL_SHIFT);
    endfunction

    state_t                     state_q, state_d;
    logic [GRID-1:0][GRID-1:0]  bitmap_q, bitmap_d;
    logic [CW-1:0]              clr_row_q, clr_row_d;
    logic [CW-1:0]              str_row_q, str_row_d, str_col_q, str_col_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_bit_q, out_bit_d;
    logic                       out_last_q, out_last_d;
    logic                       busy_q, busy_d;
    logic                       pix_in_q, pix_on_q;

    logic                       mouse_in, draw_hit, disp_in;
    logic [CW-1:0]              m_row, m_col, d_row, d_col;

    assign mouse_in = in_span(mouse_x, OX) && in_span(mouse_y, OY);
    assign m_col    = to_cell(mouse_x, OX);
    assign m_row    = to_cell(mouse_y, OY);
    assign draw_hit = mouse_event && mouse_left && mouse_in;

    assign disp_in  = in_span(h_cnt, OX) && in_span(v_cnt, OY);
    assign d_col    = to_cell(h_cnt, OX);
    assign d_row    = to_cell(v_cnt, OY);

    // Next-state, bitmap update and stream output logic.
    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        clr_row_d   = clr_row_q;
        str_row_d   = str_row_q;
        str_col_d   = str_col_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_row_d = '0;
                end else if (submit) begin
                    state_d     = ST_STREAM;
                    str_row_d   = '0;
                    str_col_d   = '0;
                    out_valid_d = 1'b1;
                    out_bit_d   = bitmap_q[0][0];
                    out_last_d  = (GRID == 1);
                end else if (draw_hit) begin
`ifdef BRUSH3_EN
                    for (int r = 0; r < int'(GRID); r++) begin
                        for (int c = 0; c < int'(GRID); c++) begin
                            if (r >= int'(m_row) - 1 && r <= int'(m_row) + 1 &&
                                c >= int'(m_col) - 1 && c <= int'(m_col) + 1) begin
                                bitmap_d[r][c] = 1'b1;
                            end
                        end
                    end
`else
                    bitmap_d[m_row][m_col] = 1'b1;
`endif
                end
            end
            ST_CLEAR: begin
                if (clear) begin
                    clr_row_d = '0;
                end else begin
                    bitmap_d[clr_row_q] = '0;
                    if (clr_row_q == LAST) begin
                        state_d   = ST_IDLE;
                        clr_row_d = '0;
                    end else begin
                        clr_row_d = CW'(clr_row_q + 1'b1);
                    end
                end
            end
            ST_STREAM: begin
                if (clear) begin
                    state_d     = ST_CLEAR;
                    clr_row_d   = '0;
                    str_row_d   = '0;
                    str_col_d   = '0;
                    out_valid_d = 1'b0;
                    out_bit_d   = 1'b0;
                    out_last_d  = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_IDLE;
                        str_row_d   = '0;
                        str_col_d   = '0;
                        out_valid_d = 1'b0;
                        out_bit_d   = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        if (str_col_q == LAST) begin
                            str_col_d = '0;
                            str_row_d = CW'(str_row_q + 1'b1);
                        end else begin
                            str_col_d = CW'(str_col_q + 1'b1);
                        end
                        out_bit_d  = bitmap_q[str_row_d][str_col_d];
                        out_last_d = (str_row_d == LAST) && (str_col_d == LAST);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitmap_q    <= '0;
            clr_row_q   <= '0;
            str_row_q   <= '0;
            str_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            pix_in_q    <= 1'b0;
            pix_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            clr_row_q   <= clr_row_d;
            str_row_q   <= str_row_d;
            str_col_q   <= str_col_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            pix_in_q    <= disp_in;
            pix_on_q    <= disp_in && bitmap_q[d_row][d_col];
        end
    end

    assign pix_in_canvas = pix_in_q;
    assign pix_on        = pix_on_q;
    assign out_valid     = out_valid_q;
    assign out_bit       = out_bit_q;
    assign out_last      = out_last_q;
    assign busy          = busy_q;

endmodule
